// File: rtl/voice_pkg.sv
// Shared constants for the channel voice back end: waveform selectors and datapath widths.
package voice_pkg;

  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_NOISE  = 2'd3;

  localparam int PHASE_W  = 32;
  localparam int TOP_W    = 8;
  localparam int SAMPLE_W = 8;
  localparam int LFSR_W   = 15;

  typedef logic [1:0] wave_sel_t;

endpackage

// File: rtl/voice_waveform_shaper.sv
// Combinational waveform shaper: maps the phase MSB byte (or the noise bit) to an 8-bit sample.
module voice_waveform_shaper
  import voice_pkg::*;
(
  input  logic [1:0]          wave_sel,
  input  logic [SAMPLE_W-1:0] phase_msb,
  input  logic                lfsr_bit,
  output logic [SAMPLE_W-1:0] sample
);

  always_comb begin
    sample = '0;
    case (wave_sel)
      WAVE_SQUARE: sample = phase_msb[7] ? 8'hFF : 8'h00;
      WAVE_SAW:    sample = phase_msb;
      // fold the upper half so the ramp goes up then back down
      WAVE_TRI:    sample = phase_msb[7] ? ~{phase_msb[6:0], 1'b0} : {phase_msb[6:0], 1'b0};
      WAVE_NOISE:  sample = {SAMPLE_W{lfsr_bit}};
      default:     sample = '0;
    endcase
  end

endmodule

// File: rtl/channel_voice_pwm.sv
// One sound channel: phase accumulator and noise LFSR feed the shaper, whose sample is
// latched at each PWM period boundary and turned into a duty-scaled pin drive.
module channel_voice_pwm
  import voice_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h0001
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [TOP_W-1:0]    i_top,
  input  logic                i_top_valid,
  input  logic [PHASE_W-1:0]  i_phase_delta,
  input  logic [1:0]          i_wave_sel,
  input  logic                i_enable,
  output logic                o_pwm,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_sample_valid
);

  logic [PHASE_W-1:0]  r_delta;
  logic [PHASE_W-1:0]  r_phase;
  logic [PHASE_W:0]    phase_sum;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [TOP_W-1:0]    r_count;
  logic [TOP_W-1:0]    r_top;
  logic [TOP_W-1:0]    r_pending;
  logic [SAMPLE_W-1:0] r_compare;

  logic                boundary;
  logic [TOP_W-1:0]    top_next;
  logic [TOP_W:0]      top_plus1;
  logic [SAMPLE_W-1:0] shaped;
  logic [SAMPLE_W-1:0] sample_next;
  logic [SAMPLE_W-1:0] compare_next;

  assign phase_sum = {1'b0, r_phase} + {1'b0, r_delta};
  assign boundary  = (r_count == r_top);

  // a top written on the boundary cycle itself must govern the period that starts next
  assign top_next  = (i_top_valid && boundary) ? i_top : r_pending;
  assign top_plus1 = {1'b0, top_next} + {{TOP_W{1'b0}}, 1'b1};

  voice_waveform_shaper u_shaper (
    .wave_sel  (i_wave_sel),
    .phase_msb (r_phase[PHASE_W-1 -: SAMPLE_W]),
    .lfsr_bit  (r_lfsr[0]),
    .sample    (shaped)
  );

  // a resting voice (zero delta) emits silence regardless of waveform
  assign sample_next = (r_delta == '0) ? '0 : shaped;

  // 8x9 product scaled back by 256; full-scale sample with top FF yields FF
  assign compare_next = 8'((17'(sample_next) * 17'(top_plus1)) >> 8);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_delta <= '0;
      r_phase <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_delta <= i_phase_delta;
      r_phase <= phase_sum[PHASE_W-1:0];
      if (phase_sum[PHASE_W]) begin
        r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[14] ^ r_lfsr[13]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= '0;
      r_top     <= 8'hFF;
      r_pending <= 8'hFF;
    end else begin
      if (i_top_valid) begin
        r_pending <= i_top;
      end
      if (boundary) begin
        r_count <= '0;
        r_top   <= top_next;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_compare      <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_pwm          <= 1'b0;
    end else begin
      o_sample_valid <= boundary;
      o_pwm          <= i_enable & (r_count < r_compare);
      if (boundary) begin
        o_sample  <= sample_next;
        r_compare <= compare_next;
      end
    end
  end

endmodule

// File: tb/tb_channel_voice_pwm.sv
// Randomized bench for channel_voice_pwm against a cycle-level arithmetic reference model.
module tb_channel_voice_pwm;

  localparam int HALF = 20;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_top;
  logic        i_top_valid;
  logic [31:0] i_phase_delta;
  logic [1:0]  i_wave_sel;
  logic        i_enable;
  logic        o_pwm;
  logic [7:0]  o_sample;
  logic        o_sample_valid;

  always #HALF i_clk = ~i_clk;

  channel_voice_pwm #(.LFSR_SEED(15'h0001)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_top          (i_top),
    .i_top_valid    (i_top_valid),
    .i_phase_delta  (i_phase_delta),
    .i_wave_sel     (i_wave_sel),
    .i_enable       (i_enable),
    .o_pwm          (o_pwm),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  longint unsigned m_phase, m_delta;
  int m_count, m_top, m_pend, m_cmp, m_lfsr, m_sample;
  bit m_pwm, m_valid;

  // per-period duty window
  bit win_armed, win_en;
  int win_highs, win_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wave_ref(input int sel, input int p, input int nbit);
    case (sel)
      0:       return (p >= 128) ? 255 : 0;
      1:       return p;
      2:       return (p < 128) ? 2 * p : 511 - 2 * p;
      default: return nbit ? 255 : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_delta = 0; m_count = 0; m_top = 255; m_pend = 255;
    m_cmp = 0; m_lfsr = 1; m_sample = 0; m_pwm = 0; m_valid = 0;
    win_armed = 0; win_en = 0; win_highs = 0; win_exp = 0;
  endtask

  // state after the next rising edge, given the inputs currently driven
  task automatic model_advance();
    bit bnd;
    int tn, s;
    longint unsigned sum;
    bit carry;
    bnd   = (m_count == m_top);
    tn    = (i_top_valid && bnd) ? int'(i_top) : m_pend;
    sum   = m_phase + m_delta;
    carry = (sum >= 64'h1_0000_0000);
    m_pwm   = i_enable && (m_count < m_cmp);
    m_valid = bnd;
    if (bnd) begin
      s = (m_delta == 0) ? 0 : wave_ref(int'(i_wave_sel), int'(m_phase >> 24), m_lfsr & 1);
      m_sample = s;
      m_cmp    = (s * (tn + 1)) / 256;
      m_top    = tn;
      m_count  = 0;
    end else begin
      m_count = m_count + 1;
    end
    if (i_top_valid) m_pend = int'(i_top);
    m_phase = sum % 64'h1_0000_0000;
    m_delta = longint'(i_phase_delta);
    if (carry) m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7FFF;
    win_en = win_en && i_enable;
  endtask

  task automatic tick();
    model_advance();
    @(negedge i_clk);
    check_eq("pwm", o_pwm, m_pwm);
    check_eq("sample", o_sample, m_sample);
    check_eq("valid", o_sample_valid, m_valid);
    win_highs += int'(o_pwm);
    if (o_sample_valid) begin
      if (win_armed && win_en) check_eq("pwm_highs", win_highs, win_exp);
      win_armed = 1; win_en = 1; win_highs = 0;
      win_exp = (m_sample * (m_top + 1)) / 256;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_top(input logic [7:0] t);
    i_top = t; i_top_valid = 1'b1;
    tick();
    i_top_valid = 1'b0; i_top = 8'($urandom);
  endtask

  int  gap;
  bit  found;

  initial begin
    i_rst = 1'b1; i_top = 8'h00; i_top_valid = 1'b0; i_phase_delta = '0;
    i_wave_sel = 2'd1; i_enable = 1'b1;
    model_reset();
    @(negedge i_clk);
    check_eq("rst_pwm", o_pwm, 0);
    check_eq("rst_sample", o_sample, 0);
    check_eq("rst_valid", o_sample_valid, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // saw, top FF: sample steps 0x10 per period, duty equals sample
    i_phase_delta = 32'h0010_0000; i_wave_sel = 2'd1;
    run(20 * 256);

    // square
    i_wave_sel = 2'd0;
    run(20 * 256);

    // top change pulsed at count 10: current period stays 256, next is 128
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_count == 10) found = 1; else tick();
    end
    check_eq("cnt10_found", found, 1);
    pulse_top(8'h7F);
    gap = 0; found = 0;
    for (int i = 1; i <= 300 && !found; i++) begin
      tick();
      if (o_sample_valid) begin found = 1; gap = i; end
    end
    check_eq("gap_old_period", gap, 245);
    gap = 0; found = 0;
    for (int i = 1; i <= 300 && !found; i++) begin
      tick();
      if (o_sample_valid) begin found = 1; gap = i; end
    end
    check_eq("gap_new_period", gap, 128);
    run(8 * 128);

    // triangle with random deltas and tops
    i_wave_sel = 2'd2;
    repeat (8) begin
      i_phase_delta = $urandom;
      if ($urandom_range(0, 1) == 1) pulse_top(8'($urandom_range(1, 255)));
      run(500);
    end

    // rest: silence even though saw is selected
    pulse_top(8'hFF);
    i_wave_sel = 2'd1; i_phase_delta = '0;
    run(6 * 256);

    // disabled saw: pin low, strobes continue
    i_phase_delta = 32'h0010_0000; i_enable = 1'b0;
    run(4 * 256);
    i_enable = 1'b1;

    // noise with shorter periods for more samples
    i_wave_sel = 2'd3; i_phase_delta = 32'h4000_0000;
    pulse_top(8'h0F);
    run(3000);

    // top 0: one-clock periods
    i_wave_sel = 2'd0; i_phase_delta = 32'h0800_0000;
    pulse_top(8'h00);
    run(60);
    pulse_top(8'hFF);
    run(600);

    // asynchronous reset mid-period
    run(77);
    @(posedge i_clk);
    #7;
    i_rst = 1'b1;
    #1;
    check_eq("async_rst_pwm", o_pwm, 0);
    check_eq("async_rst_sample", o_sample, 0);
    check_eq("async_rst_valid", o_sample_valid, 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    i_top = 8'h10; i_wave_sel = 2'd1; i_phase_delta = 32'h0100_0000;
    gap = 0; found = 0;
    for (int i = 1; i <= 300 && !found; i++) begin
      tick();
      if (o_sample_valid) begin found = 1; gap = i; end
    end
    check_eq("first_period_after_rst", gap, 256);

    // fully random mix, including mid-period waveform changes
    repeat (12000) begin
      if ($urandom_range(0, 299) == 0) i_wave_sel = 2'($urandom);
      if ($urandom_range(0, 799) == 0)
        i_phase_delta = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 399) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 499) == 0) begin
        pulse_top(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
      end else begin
        i_top = 8'($urandom);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
